dmem_ctrl: RTL and testbench

Load/store controller sitting between the MEM stage of the RISC-V core and the word-wide, single-port synchronous data memory (`d_mem`). It accepts one load or store per handshake, checks alignment and range, performs sub-word stores as read-modify-write (the RAM has no byte enables), and returns sign- or zero-extended load data. It is the only master of the data memory port.

---
 rtl/dmem_ctrl_pkg.sv | 59 +++++
 rtl/dmem_ctrl_if.sv | 31 +++
 rtl/dmem_ctrl_lsu_align.sv | 52 +++++
 rtl/dmem_ctrl.sv | 138 +++++++++++++
 tb/tb_dmem_ctrl.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : dmem_ctrl_pkg
// Purpose : Shared definitions for the data-memory load/store path. It holds
//           the RV32I load/store funct3 codes, the controller state encoding,
//           the default data-memory word-address width and a request legality
//           helper.
// Ports   : none (package)
// Revision: 1.0  initial release
// ============================================================================
package dmem_ctrl_pkg;

  // Default word-address width: 1024 words of 32 bits (4 KiB).
  localparam int DMEM_AW_DEFAULT = 10;

  // Load funct3 codes
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  // Store funct3 codes
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LD_WAIT = 2'd1,
    ST_RMW     = 2'd2
  } state_t;

  // Returns 1 for an illegal funct3 or a misaligned access. The range check
  // depends on the memory size and is done by the controller.
  function automatic logic f3_or_align_bad(input logic       we,
                                           input logic [2:0] f3,
                                           input logic [1:0] off);
    logic bad;
    bad = 1'b1;
    if (we) begin
      case (f3)
        F3_SB:   bad = 1'b0;
        F3_SH:   bad = off[0];
        F3_SW:   bad = |off;
        default: bad = 1'b1;
      endcase
    end else begin
      case (f3)
        F3_LB, F3_LBU: bad = 1'b0;
        F3_LH, F3_LHU: bad = off[0];
        F3_LW:         bad = |off;
        default:       bad = 1'b1;
      endcase
    end
    return bad;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : dmem_ctrl_if
// Purpose : Request/response bundle between the MEM stage (master) and the
//           data-memory controller (slave).
// Signals : req_valid/req_ready handshake, req_we, req_funct3, req_addr,
//           req_wdata; resp_valid pulse with resp_rdata and resp_err.
// Revision: 1.0  initial release
// ============================================================================
interface dmem_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface
`default_nettype wire

// File: rtl/dmem_ctrl_lsu_align.sv
`default_nettype none
// ============================================================================
// Module  : dmem_ctrl_lsu_align
// Purpose : Combinational lane logic. Extracts and extends the addressed
//           byte/half of a read word for loads, and merges store data into a
//           read word for sub-word read-modify-write.
// Ports   : funct3, offset (byte address bits [1:0]), rdata (RAM word),
//           wdata (right-aligned store data, low half), load_data,
//           merge_data.
// Revision: 1.0  initial release
// ============================================================================
module dmem_ctrl_lsu_align
  import dmem_ctrl_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] rdata,
  input  logic [15:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merge_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Byte lane follows addr[1:0]; half lane follows addr[1] only.
  assign w_byte = rdata[{offset, 3'b000} +: 8];
  assign w_half = offset[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    load_data = rdata;
    case (funct3)
      F3_LB:   load_data = {{24{w_byte[7]}}, w_byte};
      F3_LH:   load_data = {{16{w_half[15]}}, w_half};
      F3_LBU:  load_data = {24'd0, w_byte};
      F3_LHU:  load_data = {16'd0, w_half};
      default: load_data = rdata;
    endcase
  end

  always_comb begin
    merge_data = rdata;
    if (funct3 == F3_SB) begin
      merge_data[{offset, 3'b000} +: 8] = wdata[7:0];
    end else if (funct3 == F3_SH) begin
      if (offset[1]) merge_data[31:16] = wdata;
      else           merge_data[15:0]  = wdata;
    end
  end

endmodule
`default_nettype wire

// File: rtl/dmem_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : dmem_ctrl
// Purpose : Load/store controller between the MEM stage and the single-port
//           word-wide synchronous data RAM. Checks alignment/range, performs
//           sub-word stores as read-modify-write and returns extended load
//           data.
// Ports   : clk, rst (sync, active high); bus (dmem_ctrl_if.slave request/
//           response); mem_en, mem_we, mem_addr, mem_wdata to the RAM;
//           mem_rdata from the RAM (valid the cycle after a read).
// Revision: 1.0  initial release
// ============================================================================
module dmem_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int DMEM_AW = DMEM_AW_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  dmem_ctrl_if.slave         bus,
  output logic               mem_en,
  output logic               mem_we,
  output logic [DMEM_AW-1:0] mem_addr,
  output logic [31:0]        mem_wdata,
  input  logic [31:0]        mem_rdata
);

  state_t             r_state;
  logic [DMEM_AW-1:0] r_waddr;
  logic [1:0]         r_off;
  logic [2:0]         r_f3;
  logic [15:0]        r_wdata;
  logic               r_resp_valid;
  logic               r_resp_err;

  logic               w_accept;
  logic               w_err;
  logic               w_is_sw;
  logic [31:0]        w_load;
  logic [31:0]        w_merge;

  assign bus.req_ready = (r_state == ST_IDLE) && !rst;
  assign w_accept      = bus.req_valid && bus.req_ready;
  assign w_is_sw       = bus.req_we && (bus.req_funct3 == F3_SW);

  // Any address bit above the memory's byte range makes the request illegal.
  assign w_err = f3_or_align_bad(bus.req_we, bus.req_funct3, bus.req_addr[1:0])
               || ((bus.req_addr >> (DMEM_AW + 2)) != 32'd0);

  dmem_ctrl_lsu_align u_align (
    .funct3     (r_f3),
    .offset     (r_off),
    .rdata      (mem_rdata),
    .wdata      (r_wdata),
    .load_data  (w_load),
    .merge_data (w_merge)
  );

  // RAM port. The first access of a request is issued in the accept cycle,
  // so it is decoded straight from the request; the RMW write-back uses the
  // latched fields and the word read in the previous cycle.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = 32'd0;
    if (!rst) begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept && !w_err) begin
            mem_en   = 1'b1;
            mem_addr = bus.req_addr[DMEM_AW+1:2];
            if (w_is_sw) begin
              mem_we    = 1'b1;
              mem_wdata = bus.req_wdata;
            end
          end
        end
        ST_RMW: begin
          mem_en    = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = r_waddr;
          mem_wdata = w_merge;
        end
        default: ;
      endcase
    end
  end

  // Load responses ride on the RAM read data in the LD_WAIT cycle; all other
  // responses come from the registered pulse.
  assign bus.resp_valid = !rst && (r_resp_valid || (r_state == ST_LD_WAIT));
  assign bus.resp_err   = !rst && r_resp_valid && r_resp_err;
  assign bus.resp_rdata = (!rst && (r_state == ST_LD_WAIT)) ? w_load : 32'd0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_waddr      <= '0;
      r_off        <= 2'd0;
      r_f3         <= 3'd0;
      r_wdata      <= 16'd0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
    end else begin
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_waddr <= bus.req_addr[DMEM_AW+1:2];
            r_off   <= bus.req_addr[1:0];
            r_f3    <= bus.req_funct3;
            r_wdata <= bus.req_wdata[15:0];
            if (w_err) begin
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
            end else if (!bus.req_we) begin
              r_state <= ST_LD_WAIT;
            end else if (w_is_sw) begin
              r_resp_valid <= 1'b1;
            end else begin
              r_state <= ST_RMW;
            end
          end
        end
        ST_LD_WAIT: r_state <= ST_IDLE;
        ST_RMW: begin
          r_state      <= ST_IDLE;
          r_resp_valid <= 1'b1;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_dmem_ctrl
// Purpose : Self-checking bench for dmem_ctrl: directed cases plus random
//           traffic, checked against a byte-level reference memory model.
// Revision: 1.0  initial release
// ============================================================================
module tb_dmem_ctrl;
  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata = 32'd0;

  dmem_ctrl_if bus ();

  dmem_ctrl #(.DMEM_AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  // Environment RAM (stands in for d_mem)
  logic [31:0] ram [DEPTH];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  // Reference memory contents
  logic [31:0] ref_mem [DEPTH];

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%08h expected=0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  typedef struct {
    int          due;
    bit          err;
    logic [31:0] rdata;
    int          nmem;
  } exp_t;
  exp_t exp_q[$];

  // ---------------- reference model ----------------
  function automatic bit ref_err(input bit we, input logic [2:0] f3, input logic [31:0] a);
    int sz;
    bit legal;
    if (a >= 32'(4 * DEPTH)) return 1'b1;
    if (we) legal = (f3 <= 3'd2);
    else    legal = (f3 != 3'd3) && (f3 < 3'd6);
    if (!legal) return 1'b1;
    sz = 1 << f3[1:0];
    return (a % sz) != 0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] w, v;
    int sh;
    w  = ref_mem[a[AW+1:2]];
    sh = 8 * (a % 4);
    if (f3[1:0] == 2'd0) begin
      v = (w >> sh) & 32'hFF;
      if (!f3[2] && v >= 32'h80) v = v | 32'hFFFFFF00;
    end else if (f3[1:0] == 2'd1) begin
      v = (w >> sh) & 32'hFFFF;
      if (!f3[2] && v >= 32'h8000) v = v | 32'hFFFF0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  task automatic ref_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] mask;
    int sh;
    sh   = 8 * (a % 4);
    mask = (f3 == 3'd0) ? 32'hFF : (f3 == 3'd1) ? 32'hFFFF : 32'hFFFFFFFF;
    ref_mem[a[AW+1:2]] = (ref_mem[a[AW+1:2]] & ~(mask << sh)) | ((wd & mask) << sh);
  endtask

  // ---------------- response monitor ----------------
  int acc = 0;  // memory cycles seen since the last response
  always @(negedge clk) begin
    if (rst) begin
      acc = 0;
    end else begin
      if (bus.resp_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_resp", {31'd0, bus.resp_valid}, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("resp_cycle", cyc, e.due);
          check("resp_rdata", bus.resp_rdata, e.rdata);
          check("resp_err", {31'd0, bus.resp_err}, {31'd0, e.err});
          check("mem_cycles", acc, e.nmem);
        end
        acc = 0;
      end else begin
        check("idle_rdata", bus.resp_rdata, 32'd0);
        check("idle_err", {31'd0, bus.resp_err}, 32'd0);
        if (exp_q.size() > 0 && cyc > exp_q[0].due) begin
          check("resp_missing", {31'd0, bus.resp_valid}, 32'd1);
          void'(exp_q.pop_front());
        end
      end
      if (mem_en) acc++;
      if (!mem_en) check("we_without_en", {31'd0, mem_we}, 32'd0);
    end
  end

  // ---------------- driver ----------------
  bit busy_next = 0;  // controller expected busy in the next request cycle

  // Called just after a posedge; returns just after the posedge ending the
  // accept cycle with req_valid still high.
  task automatic do_req(input bit we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd);
    int   n;
    bit   e;
    exp_t x;
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    @(negedge clk);
    check("req_ready", {31'd0, bus.req_ready}, {31'd0, !busy_next});
    n = 0;
    while (!bus.req_ready && n < 8) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) begin
      check("accept_timeout", {31'd0, bus.req_ready}, 32'd1);
    end else begin
      e       = ref_err(we, f3, a);
      x.err   = e;
      x.rdata = (e || we) ? 32'd0 : ref_load(f3, a);
      x.nmem  = e ? 0 : (we && f3 != 3'd2) ? 2 : 1;
      x.due   = cyc + ((we && !e && f3 != 3'd2) ? 2 : 1);
      if (we && !e) ref_store(f3, a, wd);
      exp_q.push_back(x);
      busy_next = !e && (!we || f3 != 3'd2);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.req_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
    busy_next = 0;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      ram[i]     = 32'd0;
      ref_mem[i] = 32'd0;
    end
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'd0;
    bus.req_addr   = 32'd0;
    bus.req_wdata  = 32'd0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", {31'd0, bus.req_ready}, 32'd0);
    check("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    check("rst_mem_en", {31'd0, mem_en}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // SW then LW
    do_req(1, 3'b010, 32'h10, 32'hDEADBEEF);
    do_req(0, 3'b010, 32'h10, 32'd0);
    idle(2);
    // SB read-modify-write and byte loads
    do_req(1, 3'b010, 32'h20, 32'h11223344);
    do_req(1, 3'b000, 32'h22, 32'h000000AA);
    idle(1);
    do_req(0, 3'b010, 32'h20, 32'd0);
    do_req(0, 3'b000, 32'h22, 32'd0);
    do_req(0, 3'b100, 32'h22, 32'd0);
    idle(2);
    // SH over a zero word
    do_req(1, 3'b001, 32'h26, 32'h00008001);
    do_req(0, 3'b010, 32'h24, 32'd0);
    do_req(0, 3'b001, 32'h26, 32'd0);
    do_req(0, 3'b101, 32'h26, 32'd0);
    idle(2);
    // Errors
    do_req(0, 3'b010, 32'h13, 32'd0);
    do_req(1, 3'b001, 32'h21, 32'h1234);
    do_req(0, 3'b011, 32'h20, 32'd0);
    do_req(0, 3'b010, 32'h00001000, 32'd0);
    do_req(1, 3'b100, 32'h20, 32'h5);
    idle(2);
    // Back-to-back with valid held
    do_req(1, 3'b010, 32'h40, 32'hA5A5A5A5);
    do_req(1, 3'b010, 32'h44, 32'h01020304);
    do_req(0, 3'b010, 32'h40, 32'd0);
    do_req(1, 3'b000, 32'h45, 32'h000000EE);
    do_req(0, 3'b010, 32'h44, 32'd0);
    idle(3);

    // Reset during the RMW write-back cycle
    do_req(1, 3'b010, 32'h30, 32'h55667788);
    idle(2);
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 32'h30;
    bus.req_wdata  = 32'h000000CC;
    @(negedge clk);
    check("rmw_rst_ready", {31'd0, bus.req_ready}, 32'd1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("rmw_rst_mem_en", {31'd0, mem_en}, 32'd0);
    check("rmw_rst_resp", {31'd0, bus.resp_valid}, 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("rmw_rst_resp2", {31'd0, bus.resp_valid}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", {31'd0, bus.req_ready}, 32'd1);
    check("post_rst_resp", {31'd0, bus.resp_valid}, 32'd0);
    @(posedge clk);
    #1;
    busy_next = 0;
    do_req(0, 3'b010, 32'h30, 32'd0);
    idle(2);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      bit          we;
      logic [2:0]  f3;
      logic [31:0] a;
      we = $urandom_range(0, 1);
      if (we) f3 = ($urandom_range(0, 7) < 6) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(3, 7));
      else    f3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 15) == 0) a = 32'h1000 + ($urandom & 32'h0FFFFFFF);
      else                            a = 32'h80 + $urandom_range(0, 31);
      do_req(we, f3, a, $urandom);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
    end
    idle(4);
    check("pending_resps", exp_q.size(), 32'd0);

    for (int i = 0; i < 64; i++) begin
      check("ram_word", ram[i], ref_mem[i]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
